// File: rtl/issue_unit.sv
// In-order issue FIFO between decode and the INT/LSU/VEC units.
// Head entry is offered to one unit; non-one-hot selects are dropped.
module issue_unit #(
  parameter int DEPTH = 4
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       flush_in,
  input  logic       dec_valid_in,
  output logic       dec_ready_out,
  input  logic [2:0] exec_sel_in,
  input  logic [3:0] exec_uop_in,
  input  logic       pc_mux_sel_in,
  input  logic       imm_mux_sel_in,
  input  logic [4:0] rs1_in,
  input  logic [4:0] rs2_in,
  input  logic [4:0] rd_in,
  output logic       int_valid_out,
  input  logic       int_ready_in,
  output logic       lsu_valid_out,
  input  logic       lsu_ready_in,
  output logic       vec_valid_out,
  input  logic       vec_ready_in,
  output logic [3:0] iss_uop_out,
  output logic       iss_pc_mux_sel_out,
  output logic       iss_imm_mux_sel_out,
  output logic [4:0] iss_rs1_out,
  output logic [4:0] iss_rs2_out,
  output logic [4:0] iss_rd_out,
  output logic       illegal_out
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] uop;
    logic       pc;
    logic       imm;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          din;
  ent_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          head_valid;
  logic          legal;
  logic          fire;
  logic          push;
  logic          pop;

  assign din = '{
    sel: exec_sel_in,
    uop: exec_uop_in,
    pc:  pc_mux_sel_in,
    imm: imm_mux_sel_in,
    rs1: rs1_in,
    rs2: rs2_in,
    rd:  rd_in
  };

  assign head       = mem[rd_ptr];
  assign head_valid = (count != '0);

  assign legal = (head.sel == 3'b001)
               | (head.sel == 3'b010)
               | (head.sel == 3'b100);

  assign int_valid_out = head_valid & (head.sel == 3'b001);
  assign lsu_valid_out = head_valid & (head.sel == 3'b010);
  assign vec_valid_out = head_valid & (head.sel == 3'b100);
  assign illegal_out   = head_valid & ~legal;

  assign fire = (int_valid_out & int_ready_in)
              | (lsu_valid_out & lsu_ready_in)
              | (vec_valid_out & vec_ready_in);

  // Illegal heads drain without a handshake.
  assign pop  = fire | illegal_out;

  // Registered occupancy only: no path from any unit ready.
  assign dec_ready_out = (count != CW'(DEPTH));
  assign push          = dec_valid_in & dec_ready_out;

  assign iss_uop_out         = head.uop;
  assign iss_pc_mux_sel_out  = head.pc;
  assign iss_imm_mux_sel_out = head.imm;
  assign iss_rs1_out         = head.rs1;
  assign iss_rs2_out         = head.rs2;
  assign iss_rd_out          = head.rd;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
